// File: rtl/icache_pkg.sv
// Shared types and geometry constants for the instruction-cache responder.
package icache_pkg;

  localparam int unsigned ADDR_W         = 30;
  localparam int unsigned ASID_W         = 9;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DEF_LINES      = 64;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_OFF_W      = $clog2(DEF_LINE_WORDS);
  localparam int unsigned DEF_IDX_W      = $clog2(DEF_LINES);
  localparam int unsigned DEF_TAG_W      = ADDR_W - DEF_OFF_W - DEF_IDX_W;
  // Tag field sized for the smallest geometry (2 lines x 2 words) so every instance fits.
  localparam int unsigned TAG_MAX_W      = ADDR_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } icache_state_e;

  typedef struct packed {
    logic [ASID_W-1:0]    asid;
    logic [TAG_MAX_W-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/icache_resp_if.sv
// Fetch-side request/response and memory refill signals of the instruction cache.
interface icache_resp_if #(
  parameter int unsigned LINE_WORDS = icache_pkg::DEF_LINE_WORDS
);
  import icache_pkg::*;

  localparam int unsigned MEM_AW = ADDR_W - $clog2(LINE_WORDS);

  logic              fe0_read_req;
  logic [ASID_W-1:0] fe0_read_asid;
  logic [ADDR_W-1:0] fe0_read_addr;
  logic              csr_kill;
  logic              ic_flush;
  logic              ic_valid;
  logic [DATA_W-1:0] ic_data;
  logic              ic_stall;
  logic              ic_mem_req;
  logic [MEM_AW-1:0] ic_mem_addr;
  logic              ic_mem_ack;
  logic              ic_mem_rvalid;
  logic [DATA_W-1:0] ic_mem_rdata;

  modport slave (
    input  fe0_read_req, fe0_read_asid, fe0_read_addr, csr_kill, ic_flush,
    input  ic_mem_ack, ic_mem_rvalid, ic_mem_rdata,
    output ic_valid, ic_data, ic_stall, ic_mem_req, ic_mem_addr
  );

  modport master (
    output fe0_read_req, fe0_read_asid, fe0_read_addr, csr_kill, ic_flush,
    output ic_mem_ack, ic_mem_rvalid, ic_mem_rdata,
    input  ic_valid, ic_data, ic_stall, ic_mem_req, ic_mem_addr
  );

endinterface

// File: rtl/icache_ram.sv
// Synchronous-read array with one write port and a read enable.
module icache_ram #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_core,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_core) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/icache_resp.sv
// Direct-mapped ASID-tagged instruction cache: 1-cycle hit, line refill FSM on miss.
module icache_resp
  import icache_pkg::*;
#(
  parameter int unsigned LINES      = DEF_LINES,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
  input logic          clk_core,
  input logic          reset,
  icache_resp_if.slave bus
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned DADR_W = IDX_W + OFF_W;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_FILL = ST_FILL;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]        state_q, state_d;
  logic              req_v_q, kill_pend_q, flush_pend_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ASID_W-1:0] asid_q;
  logic [OFF_W-1:0]  cnt_q;
  logic [DATA_W-1:0] fill_word_q;
  logic [LINES-1:0]  valid_q;

  logic [OFF_W-1:0]  off_q;
  logic [IDX_W-1:0]  idx_q;
  tag_entry_t        tag_exp, tag_rd;
  logic [DATA_W-1:0] data_rd;
  logic              cmp_act, hit, miss, accept, fill_we, last_beat, flush_any, clear_all;
  logic              valid_c, stall_c, mem_req_c;
  logic [DATA_W-1:0] data_c;

  assign off_q     = addr_q[OFF_W-1:0];
  assign idx_q     = addr_q[OFF_W +: IDX_W];
  assign tag_exp   = '{asid: asid_q, tag: TAG_MAX_W'(addr_q[ADDR_W-1 -: TAG_W])};

  // A kill retires the outstanding request before it can hit or miss.
  assign cmp_act   = req_v_q & ~bus.csr_kill & (state_q == S_IDLE);
  assign hit       = cmp_act & valid_q[idx_q] & (tag_rd == tag_exp);
  assign miss      = cmp_act & ~hit;
  assign accept    = bus.fe0_read_req & (state_q == S_IDLE) & ~miss;
  assign fill_we   = (state_q == S_FILL) & bus.ic_mem_rvalid;
  assign last_beat = fill_we & (cnt_q == OFF_W'(LINE_WORDS - 1));
  assign flush_any = flush_pend_q | bus.ic_flush;
  assign clear_all = ((state_q == S_IDLE) & bus.ic_flush) | (last_beat & flush_any) |
                     ((state_q == S_DONE) & flush_any);

  icache_ram #(.DEPTH(LINES * LINE_WORDS), .WIDTH(DATA_W)) u_data (
    .clk_core (clk_core),
    .we       (fill_we),
    .waddr    ({idx_q, cnt_q}),
    .wdata    (bus.ic_mem_rdata),
    .re       (accept),
    .raddr    (bus.fe0_read_addr[DADR_W-1:0]),
    .rdata    (data_rd)
  );

  icache_ram #(.DEPTH(LINES), .WIDTH($bits(tag_entry_t))) u_tag (
    .clk_core (clk_core),
    .we       (last_beat),
    .waddr    (idx_q),
    .wdata    (tag_exp),
    .re       (accept),
    .raddr    (bus.fe0_read_addr[OFF_W +: IDX_W]),
    .rdata    (tag_rd)
  );

  always_ff @(posedge clk_core) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and fetch-facing outputs.
  always_comb begin
    state_d   = state_q;
    valid_c   = 1'b0;
    stall_c   = 1'b0;
    mem_req_c = 1'b0;
    data_c    = data_rd;
    case (state_q)
      S_IDLE: begin
        valid_c = hit;
        stall_c = miss;
        if (miss) state_d = S_REQ;
      end
      S_REQ: begin
        stall_c   = 1'b1;
        mem_req_c = 1'b1;
        if (bus.ic_mem_ack) state_d = S_FILL;
      end
      S_FILL: begin
        stall_c = 1'b1;
        if (last_beat) state_d = S_DONE;
      end
      S_DONE: begin
        valid_c = ~kill_pend_q & ~bus.csr_kill;
        data_c  = fill_word_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ic_valid    = valid_c;
  assign bus.ic_data     = data_c;
  assign bus.ic_stall    = stall_c;
  assign bus.ic_mem_req  = mem_req_c;
  assign bus.ic_mem_addr = addr_q[ADDR_W-1:OFF_W];

  always_ff @(posedge clk_core) begin
    if (reset) begin
      req_v_q      <= 1'b0;
      kill_pend_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= '0;
      cnt_q        <= '0;
    end else begin
      req_v_q <= accept;
      if (state_q == S_DONE)
        kill_pend_q <= 1'b0;
      else if (bus.csr_kill && (state_q == S_REQ || state_q == S_FILL))
        kill_pend_q <= 1'b1;
      if (clear_all)
        flush_pend_q <= 1'b0;
      else if (bus.ic_flush && state_q != S_IDLE)
        flush_pend_q <= 1'b1;
      // A line filled under a pending flush is written but never marked valid.
      if (clear_all)      valid_q        <= '0;
      else if (last_beat) valid_q[idx_q] <= 1'b1;
      if (state_q == S_REQ) cnt_q <= '0;
      else if (fill_we)     cnt_q <= cnt_q + OFF_W'(1);
    end
  end

  always_ff @(posedge clk_core) begin
    if (accept) begin
      addr_q <= bus.fe0_read_addr;
      asid_q <= bus.fe0_read_asid;
    end
    if (fill_we && cnt_q == off_q) fill_word_q <= bus.ic_mem_rdata;
  end

endmodule

// File: tb/tb_icache_resp.sv
// Directed self-checking bench for icache_resp; the bench also plays the memory side.
module tb_icache_resp;

  logic        clk_core = 1'b0;
  logic        reset;
  int          n_total = 0;
  int          n_pass  = 0;
  logic        done_v, done_s;
  logic [31:0] done_d;

  icache_resp_if #(.LINE_WORDS(4)) bus ();

  icache_resp #(.LINES(64), .LINE_WORDS(4)) dut (
    .clk_core (clk_core),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk_core = ~clk_core;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_total++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, want);
  endtask

  // Inputs change 2ns after the rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_core);
    #2;
  endtask

  task automatic access(input logic [29:0] a, input logic [8:0] s);
    tick();
    bus.fe0_read_req  = 1'b1;
    bus.fe0_read_addr = a;
    bus.fe0_read_asid = s;
    tick();
    bus.fe0_read_req  = 1'b0;
    #1;
  endtask

  task automatic wait_req(input logic [27:0] line);
    int n = 0;
    while (bus.ic_mem_req !== 1'b1 && n < 8) begin
      tick();
      #1;
      n++;
    end
    chk("mem_req", 32'(bus.ic_mem_req), 32'd1);
    chk("mem_addr", 32'(bus.ic_mem_addr), 32'(line));
    bus.ic_mem_ack = 1'b1;
    tick();
    bus.ic_mem_ack = 1'b0;
  endtask

  // Called in the miss-detect cycle; returns the DONE-cycle outputs.
  task automatic refill(input logic [27:0] line, input logic [31:0] base,
                        input int gap_at, input int kill_at, input int flush_at,
                        output logic v, output logic [31:0] d, output logic st);
    chk("miss_stall", 32'(bus.ic_stall), 32'd1);
    chk("miss_valid", 32'(bus.ic_valid), 32'd0);
    wait_req(line);
    for (int i = 0; i < 4; i++) begin
      bus.ic_mem_rvalid = 1'b1;
      bus.ic_mem_rdata  = base + 32'(i);
      #1;
      if (i == 0) begin
        chk("fill_stall", 32'(bus.ic_stall), 32'd1);
        chk("fill_memreq", 32'(bus.ic_mem_req), 32'd0);
      end
      tick();
      bus.ic_mem_rvalid = 1'b0;
      if (i == gap_at)   tick();
      if (i == kill_at)  begin bus.csr_kill = 1'b1; tick(); bus.csr_kill = 1'b0; end
      if (i == flush_at) begin bus.ic_flush = 1'b1; tick(); bus.ic_flush = 1'b0; end
    end
    #1;
    v  = bus.ic_valid;
    d  = bus.ic_data;
    st = bus.ic_stall;
  endtask

  initial begin
    reset             = 1'b1;
    bus.fe0_read_req  = 1'b0;
    bus.fe0_read_asid = '0;
    bus.fe0_read_addr = '0;
    bus.csr_kill      = 1'b0;
    bus.ic_flush      = 1'b0;
    bus.ic_mem_ack    = 1'b0;
    bus.ic_mem_rvalid = 1'b0;
    bus.ic_mem_rdata  = '0;
    repeat (3) tick();
    #1;
    chk("rst_valid", 32'(bus.ic_valid), 32'd0);
    chk("rst_stall", 32'(bus.ic_stall), 32'd0);
    chk("rst_memreq", 32'(bus.ic_mem_req), 32'd0);
    reset = 1'b0;

    // Cold miss at byte 0x104, beats A0..A3 with a gap after beat 0
    access(30'h41, 9'd3);
    refill(28'h10, 32'hA0, 0, -1, -1, done_v, done_d, done_s);
    chk("cold_done_valid", 32'(done_v), 32'd1);
    chk("cold_done_data", done_d, 32'hA1);
    chk("cold_done_stall", 32'(done_s), 32'd0);

    // Hit at byte 0x108, then ASID mismatch on the same line
    access(30'h42, 9'd3);
    chk("hit_valid", 32'(bus.ic_valid), 32'd1);
    chk("hit_data", bus.ic_data, 32'hA2);
    chk("hit_stall", 32'(bus.ic_stall), 32'd0);
    chk("hit_memreq", 32'(bus.ic_mem_req), 32'd0);
    access(30'h42, 9'd4);
    refill(28'h10, 32'hB0, -1, -1, -1, done_v, done_d, done_s);
    chk("asid_done_data", done_d, 32'hB2);

    // Conflict: 0x100 and 0x500 share index 16
    access(30'h40, 9'd3);
    refill(28'h10, 32'hC0, -1, -1, -1, done_v, done_d, done_s);
    chk("conf_fill_data", done_d, 32'hC0);
    access(30'h40, 9'd3);
    chk("conf_hit_data", bus.ic_data, 32'hC0);
    access(30'h140, 9'd3);
    refill(28'h50, 32'hD0, -1, -1, -1, done_v, done_d, done_s);
    chk("evict_data", done_d, 32'hD0);
    access(30'h40, 9'd3);
    refill(28'h10, 32'hE0, -1, -1, -1, done_v, done_d, done_s);
    chk("reload_data", done_d, 32'hE0);

    // Kill mid-fill: line completes but no response
    access(30'h83, 9'd3);
    refill(28'h20, 32'hF0, -1, 1, -1, done_v, done_d, done_s);
    chk("kill_done_valid", 32'(done_v), 32'd0);
    access(30'h83, 9'd3);
    chk("kill_after_valid", 32'(bus.ic_valid), 32'd1);
    chk("kill_after_data", bus.ic_data, 32'hF3);

    // Kill on a hit with a simultaneous new request
    tick();
    bus.fe0_read_req  = 1'b1;
    bus.fe0_read_addr = 30'h83;
    tick();
    bus.fe0_read_addr = 30'h82;
    bus.csr_kill      = 1'b1;
    #1;
    chk("kill_hit_valid", 32'(bus.ic_valid), 32'd0);
    tick();
    bus.fe0_read_req = 1'b0;
    bus.csr_kill     = 1'b0;
    #1;
    chk("redirect_valid", 32'(bus.ic_valid), 32'd1);
    chk("redirect_data", bus.ic_data, 32'hF2);
    tick();
    #1;
    chk("no_spurious", 32'(bus.ic_valid), 32'd0);

    // Flush in the compare cycle of a hit: hit returned, then line gone
    tick();
    bus.fe0_read_req  = 1'b1;
    bus.fe0_read_addr = 30'h82;
    tick();
    bus.fe0_read_req = 1'b0;
    bus.ic_flush     = 1'b1;
    #1;
    chk("flush_hit_valid", 32'(bus.ic_valid), 32'd1);
    chk("flush_hit_data", bus.ic_data, 32'hF2);
    tick();
    bus.ic_flush = 1'b0;
    access(30'h83, 9'd3);
    refill(28'h20, 32'h10, -1, -1, 1, done_v, done_d, done_s);
    chk("flushfill_valid", 32'(done_v), 32'd1);
    chk("flushfill_data", done_d, 32'h13);
    access(30'h83, 9'd3);
    refill(28'h20, 32'h20, -1, -1, -1, done_v, done_d, done_s);
    chk("postflush_data", done_d, 32'h23);
    access(30'h81, 9'd3);
    chk("postflush_hit", bus.ic_data, 32'h21);

    // Reset after beat 2 of a fill
    access(30'hC1, 9'd3);
    chk("rf_miss_stall", 32'(bus.ic_stall), 32'd1);
    wait_req(28'h30);
    for (int i = 0; i < 3; i++) begin
      bus.ic_mem_rvalid = 1'b1;
      bus.ic_mem_rdata  = 32'h30 + 32'(i);
      tick();
    end
    bus.ic_mem_rvalid = 1'b0;
    reset             = 1'b1;
    tick();
    #1;
    chk("rf_rst_valid", 32'(bus.ic_valid), 32'd0);
    chk("rf_rst_stall", 32'(bus.ic_stall), 32'd0);
    chk("rf_rst_memreq", 32'(bus.ic_mem_req), 32'd0);
    tick();
    reset             = 1'b0;
    bus.ic_mem_rvalid = 1'b1;
    bus.ic_mem_rdata  = 32'hDEAD;
    tick();
    bus.ic_mem_rvalid = 1'b0;
    #1;
    chk("stray_stall", 32'(bus.ic_stall), 32'd0);
    chk("stray_valid", 32'(bus.ic_valid), 32'd0);
    access(30'hC1, 9'd3);
    refill(28'h30, 32'h40, -1, -1, -1, done_v, done_d, done_s);
    chk("rf_refill_data", done_d, 32'h41);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/icache_resp.md
Name: icache_resp

Overview:
- Instruction-cache responder: the consumer end of the fetch0 read-request interface (fe0_read_req/asid/addr).
- Direct-mapped, ASID-tagged cache with single-cycle hit latency. Returns the instruction word toward fetch1.
- Asserts ic_stall while refilling a line from the memory bus.
- Sits between fetch0/fetch1 and the memory arbiter.

Parameters:
LINES, 64, number of cache lines (power of 2, >=2)
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)

Ports:
clk_core  in  1  core clock
reset  in  1  synchronous active-high reset
fe0_read_req  in  1  fetch read request this cycle
fe0_read_asid  in  9  ASID of request
fe0_read_addr  in  30  word address [31:2]
csr_kill  in  1  discard outstanding response
ic_flush  in  1  invalidate all lines (fence.i)
ic_valid  out  1  ic_data valid this cycle
ic_data  out  32  instruction word
ic_stall  out  1  miss in progress; fetch must hold
ic_mem_req  out  1  line refill request
ic_mem_addr  out  28  line address [31:4] (width = 30 - log2(LINE_WORDS))
ic_mem_ack  in  1  refill request accepted
ic_mem_rvalid  in  1  refill beat valid
ic_mem_rdata  in  32  refill beat data

Behaviour:
- Address split:
  - OFF = log2(LINE_WORDS), IDX = log2(LINES).
  - offset = addr[OFF+1:2]; index = next IDX bits; tag = remaining upper bits.
  - Stored tag = {asid, addr tag}.
- Storage:
  - Data and tag arrays are synchronous-read, one write port.
  - Valid bits are flops, cleared by reset.
- Request stage:
  - When fe0_read_req=1 and FSM is IDLE, register addr/asid (req_q valid) and read the arrays.
  - Requests while ic_stall=1 are ignored; fetch0 holds them via fe1_stall.
- Compare stage (cycle N+1):
  - Hit = valid[idx] & tag match → ic_valid=1 and ic_data=word[offset] in the same cycle. Hit latency is 1 cycle.
  - Miss → ic_valid=0, go REQ. ic_stall=1 from this cycle.
- FSM states: IDLE, REQ, FILL, DONE.
  - IDLE: on miss → REQ.
  - REQ: ic_mem_req=1 with the line address. On ic_mem_ack → FILL, beat counter=0.
  - FILL: each ic_mem_rvalid writes ic_mem_rdata to word[counter] and increments counter. After beat LINE_WORDS-1: write tag, set valid → DONE.
  - DONE: ic_valid=1 with the requested word (captured during fill), ic_stall=0 → IDLE.
- ic_stall = 1 in the miss-detect cycle, REQ and FILL; 0 in DONE and IDLE.
- ic_mem_req holds until ack. Beats arrive in order, word 0 first, and may have gaps.
- csr_kill:
  - Clears req_q; an in-flight hit response in the same cycle is suppressed (ic_valid=0).
  - During REQ/FILL: the refill completes (the bus cannot abort), but DONE produces no ic_valid.
  - Kill in IDLE with no request: no effect.
- ic_flush:
  - In IDLE: clear all valid bits next edge. A hit in the same compare cycle is still returned.
  - In REQ/FILL/DONE: latch flush_pend. At fill end, the filled line is written but left invalid, then all valids are cleared; the DONE response is still returned.
- Simultaneous csr_kill and fe0_read_req: the new request is accepted (fetch0 redirect case); the kill applies only to the previously outstanding one.
- Reset:
  - ic_valid=0, ic_stall=0, ic_mem_req=0, FSM=IDLE, all valid bits=0, flush_pend=0, req_q invalid.
  - Reset mid-fill abandons the fill; remaining beats arriving after reset are ignored in IDLE.
- Beat counter wraps naturally at LINE_WORDS; no overflow is possible because FILL exits on the last beat.

Decomposition:
- Shared package icache_pkg:
  - icache_state_e enum (IDLE/REQ/FILL/DONE)
  - localparams for OFF/IDX/TAG widths
  - tag-entry struct {asid[8:0], tag}
- One sub-module: icache_ram, a parameterised synchronous-read single-write-port array. Instantiated twice, for data and for tags.

Test Plan:
1. Cold miss: after reset, request addr 0x0000_0104>>2, asid 3 → ic_stall=1 and ic_mem_req with line 0x10. Feed 4 beats 0xA0..0xA3 → DONE cycle gives ic_valid=1, ic_data=0xA1.
2. Hit: repeat addr 0x108>>2, asid 3 → ic_valid next cycle with data 0xA2, no ic_mem_req. Same addr with asid 4 → miss.
3. Conflict: fill line at 0x100, then access 0x100 + LINES*16 → miss, refill evicts. Re-access 0x100 → miss.
4. Kill mid-fill: csr_kill in FILL after beat 1 → fill completes, no ic_valid. Subsequent access to the same address hits.
5. Flush: ic_flush in IDLE → prior hit addresses miss. ic_flush during FILL → DONE still returns data; the next access to the same line misses.
6. Reset mid-fill: assert reset after beat 2 → outputs at reset values. Stray rvalid beats ignored; the next access to that line misses.
